// File: rtl/aes_enc_round.sv
// Iterative AES-128 encryption core: one round per round-key step, with the
// round keys streamed in from an external key_expansion block.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] b_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign b_o = SBOX[a_i];

endmodule

module aes_enc_round #(
  parameter int KEY_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         start_enc,
  output logic         ready_enc,
  input  logic [127:0] key_enc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} fsm_e;

  localparam logic [2:0] WAIT_LAST = 3'(KEY_LAT - 1);

  fsm_e         fsm_q;
  logic [3:0]   rnd_q;
  logic [2:0]   wcnt_q;
  logic [127:0] st_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         start_enc_q;
  logic         ready_enc_q;
  logic [127:0] data_out_q;

  logic [127:0] sb_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;
  logic [127:0] round_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (st_q[127-8*g -: 8]),
      .b_o (sb_s[127-8*g -: 8])
    );
  end

  // Byte (row r, column c) sits at index 4*c+r; ShiftRows pulls column (c+r)%4.
  always_comb begin
    sr_s = 128'h0;
    mc_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[127-8*(4*c+r) -: 8] = sb_s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[127-32*c -: 32] = mix_col(sr_s[127-32*c -: 32]);
    end
    if (rnd_q == 4'd0) begin
      round_d = st_q ^ key_enc;
    end else if (rnd_q == 4'd10) begin
      round_d = sr_s ^ key_enc;
    end else begin
      round_d = mc_s ^ key_enc;
    end
  end

  // Control FSM, round state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      wcnt_q      <= 3'd0;
      st_q        <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      start_enc_q <= 1'b0;
      ready_enc_q <= 1'b0;
      data_out_q  <= 128'h0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            st_q        <= data_in;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            start_enc_q <= 1'b1;
            fsm_q       <= REQ;
          end
        end
        REQ: begin
          start_enc_q <= 1'b0;
          ready_enc_q <= 1'b0;
          wcnt_q      <= 3'd0;
          fsm_q       <= WAIT;
        end
        WAIT: begin
          if (wcnt_q == WAIT_LAST) begin
            st_q <= round_d;
            if (rnd_q == 4'd10) begin
              data_out_q  <= round_d;
              out_valid_q <= 1'b1;
              fsm_q       <= DONE;
            end else begin
              rnd_q       <= rnd_q + 4'd1;
              ready_enc_q <= 1'b1;
              fsm_q       <= REQ;
            end
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign start_enc = start_enc_q;
  assign ready_enc = ready_enc_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes_enc_round.sv
// Directed bench for aes_enc_round: FIPS-197 vectors, key-pulse accounting,
// output backpressure, mid-block reset and back-to-back blocks with KEY_LAT=3.

module tb_aes_enc_round;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [127:0] data_in = 128'h0, data_in3 = 128'h0;
  logic in_valid = 1'b0, in_valid3 = 1'b0;
  logic out_ready = 1'b1, out_ready3 = 1'b1;
  logic [127:0] key_enc = 128'h0, key_enc3 = 128'h0;
  logic in_ready, in_ready3, out_valid, out_valid3;
  logic start_enc, start_enc3, ready_enc, ready_enc3;
  logic [127:0] data_out, data_out3;

  int n_checks = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] rk_cur [0:10];

  always #5 clk = ~clk;

  aes_enc_round #(.KEY_LAT(1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .start_enc(start_enc), .ready_enc(ready_enc), .key_enc(key_enc)
  );

  aes_enc_round #(.KEY_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in3), .in_valid(in_valid3), .in_ready(in_ready3),
    .data_out(data_out3), .out_valid(out_valid3), .out_ready(out_ready3),
    .start_enc(start_enc3), .ready_enc(ready_enc3), .key_enc(key_enc3)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference GF(2^8) arithmetic used to build the S-box for the key model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_cur[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // key_expansion model, KEY_LAT=1: next key visible right after the pulse is sampled.
  int kidx = 0;
  always @(posedge clk) begin
    if (start_enc) begin
      kidx    <= 0;
      key_enc <= rk_cur[0];
    end else if (ready_enc) begin
      kidx    <= kidx + 1;
      key_enc <= rk_cur[(kidx < 10) ? kidx + 1 : 10];
    end
  end

  // key_expansion model, KEY_LAT=3: garbage until two edges after the pulse.
  int kidx3 = 0;
  int kcnt3 = 0;
  always @(posedge clk) begin
    if (start_enc3 || ready_enc3) begin
      kidx3    <= start_enc3 ? 0 : kidx3 + 1;
      kcnt3    <= 2;
      key_enc3 <= 128'hdeadbeef_0badf00d_cafebabe_5a5a5a5a;
    end else if (kcnt3 > 0) begin
      kcnt3 <= kcnt3 - 1;
      if (kcnt3 == 1) key_enc3 <= rk_cur[(kidx3 < 10) ? kidx3 : 10];
    end
  end

  int n_start = 0, n_ready = 0, n_overlap = 0;
  int n_start3 = 0, n_ready3 = 0, n_overlap3 = 0;
  always @(posedge clk) begin
    if (start_enc === 1'b1) n_start <= n_start + 1;
    if (ready_enc === 1'b1) n_ready <= n_ready + 1;
    if (start_enc === 1'b1 && ready_enc === 1'b1) n_overlap <= n_overlap + 1;
    if (start_enc3 === 1'b1) n_start3 <= n_start3 + 1;
    if (ready_enc3 === 1'b1) n_ready3 <= n_ready3 + 1;
    if (start_enc3 === 1'b1 && ready_enc3 === 1'b1) n_overlap3 <= n_overlap3 + 1;
  end

  // Present one block to the KEY_LAT=1 instance and wait for its result.
  task automatic run1(input string tag, input logic [127:0] pt, input logic [127:0] ct);
    int edges;
    logic rdy_seen;
    check_eq({tag, "_in_ready"}, {127'h0, in_ready}, 128'h1);
    in_valid = 1'b1;
    data_in  = pt;
    tick();
    in_valid = 1'b0;
    data_in  = ~pt;
    edges    = 0;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && edges < 200) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      tick();
      edges++;
    end
    check_eq({tag, "_latency"}, 128'(edges), 128'd22);
    check_eq({tag, "_busy_in_ready"}, {127'h0, rdy_seen}, 128'h0);
    check_eq({tag, "_data_out"}, data_out, ct);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, ns, nr;
    logic ov_seen;
    for (int v = 0; v < 256; v++) sbox_t[v] = sbox_calc(8'(v));
    expand_key(KEY_C1);

    // Reset values.
    tick();
    tick();
    check_eq("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check_eq("rst_start_enc", {127'h0, start_enc}, 128'h0);
    check_eq("rst_ready_enc", {127'h0, ready_enc}, 128'h0);
    check_eq("rst_data_out", data_out, 128'h0);
    check_eq("rst_data_out3", data_out3, 128'h0);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready", {127'h0, in_ready}, 128'h1);
    check_eq("rst_in_ready3", {127'h0, in_ready3}, 128'h1);

    // FIPS-197 C.1 with immediate handshake.
    run1("c1", PT_C1, CT_C1);
    tick();
    check_eq("c1_ready_after_hs", {127'h0, in_ready}, 128'h1);
    check_eq("c1_valid_after_hs", {127'h0, out_valid}, 128'h0);

    // FIPS-197 App.B with key-pulse accounting.
    expand_key(KEY_B);
    ns = n_start;
    nr = n_ready;
    run1("appb", PT_B, CT_B);
    check_eq("appb_start_pulses", 128'(n_start - ns), 128'd1);
    check_eq("appb_ready_pulses", 128'(n_ready - nr), 128'd10);
    check_eq("appb_overlap", 128'(n_overlap), 128'd0);
    tick();

    // Output backpressure for five cycles.
    expand_key(KEY_C1);
    out_ready = 1'b0;
    run1("bp", PT_C1, CT_C1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_valid", {127'h0, out_valid}, 128'h1);
      check_eq("bp_hold_data", data_out, CT_C1);
      check_eq("bp_hold_in_ready", {127'h0, in_ready}, 128'h0);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_ready_after_hs", {127'h0, in_ready}, 128'h1);
    check_eq("bp_valid_after_hs", {127'h0, out_valid}, 128'h0);

    // Reset during round 4, with in_valid raised while rst is high.
    nr = n_ready;
    in_valid = 1'b1;
    data_in  = PT_C1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check_eq("mid_ready_pulses", 128'(n_ready - nr), 128'd4);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    ns       = n_start;
    nr       = n_ready;
    ov_seen  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    check_eq("mid_no_out_valid", {127'h0, ov_seen}, 128'h0);
    check_eq("mid_no_start", 128'(n_start - ns), 128'd0);
    check_eq("mid_no_ready", 128'(n_ready - nr), 128'd0);
    run1("post_rst", PT_C1, CT_C1);
    tick();

    // KEY_LAT=3, two back-to-back C.1 blocks with in_valid held high.
    check_eq("kl3_in_ready", {127'h0, in_ready3}, 128'h1);
    in_valid3 = 1'b1;
    data_in3  = PT_C1;
    for (int b = 0; b < 2; b++) begin
      tick();
      edges = 0;
      while (out_valid3 !== 1'b1 && edges < 300) begin
        tick();
        edges++;
      end
      if (b == 1) in_valid3 = 1'b0;
      check_eq("kl3_latency", 128'(edges), 128'd44);
      check_eq("kl3_data_out", data_out3, CT_C1);
      tick();
      check_eq("kl3_ready_after_hs", {127'h0, in_ready3}, 128'h1);
      check_eq("kl3_valid_after_hs", {127'h0, out_valid3}, 128'h0);
    end
    check_eq("kl3_start_pulses", 128'(n_start3), 128'd2);
    check_eq("kl3_ready_pulses", 128'(n_ready3), 128'd20);
    check_eq("kl3_overlap", 128'(n_overlap3), 128'd0);
    check_eq("kl1_overlap_total", 128'(n_overlap), 128'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_enc_round.md
AES_ENC_ROUND -- requirements
Module: aes_enc_round

Interface
REQ-001 SHALL have parameter KEY_LAT, default 1, meaning the number of cycles (1..4) after a key request pulse before key_enc holds the requested round key.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port data_in  input  128  plaintext block.
REQ-005 SHALL have port in_valid  input  1  data_in is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a plaintext.
REQ-007 SHALL have port data_out  output  128  ciphertext block.
REQ-008 SHALL have port out_valid  output  1  data_out is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts data_out.
REQ-010 SHALL have port start_enc  output  1  one-cycle pulse that rewinds key_expansion to the round-0 key.
REQ-011 SHALL have port ready_enc  output  1  one-cycle pulse that advances key_expansion to the next round key.
REQ-012 SHALL have port key_enc  input  128  current round key from key_expansion.

Function
REQ-013 SHALL be an iterative AES-128 encryptor (FIPS-197), one round per key step, consuming round keys 0..10 from key_expansion.
REQ-014 SHALL use byte order with byte 0 = bits [127:120], state column-major (bytes 0-3 = column 0).
REQ-015 SHALL implement the FSM states IDLE, REQ, WAIT and DONE, with a 4-bit round counter rnd running 0..10.
REQ-016 SHALL, in IDLE, drive in_ready=1; on in_valid&&in_ready, capture data_in, set rnd=0 and go to REQ.
REQ-017 SHALL, in REQ, drive start_enc=1 when rnd=0 and otherwise drive ready_enc=1, for exactly one cycle, then go to WAIT.
REQ-018 SHALL stay in WAIT for KEY_LAT cycles; on the edge ending the last WAIT cycle, apply round rnd using the current key_enc.
REQ-019 SHALL apply round 0 as state ^= key_enc.
REQ-020 SHALL apply rounds 1..9 as SubBytes, ShiftRows, MixColumns, then XOR with key_enc.
REQ-021 SHALL apply round 10 as SubBytes, ShiftRows, then XOR with key_enc, with no MixColumns.
REQ-022 SHALL, after applying round rnd<10, increment rnd and return to REQ; after round 10, go to DONE.
REQ-023 SHALL implement SubBytes with 16 instances of the codebase combinational aes_sbox; MixColumns SHALL use xtime over GF(2^8) with polynomial 0x11B.
REQ-024 SHALL, in DONE, drive out_valid=1 and data_out = final state, both held stable until out_ready=1; on out_valid&&out_ready, go to IDLE.
REQ-025 SHALL raise out_valid on the 11*(1+KEY_LAT)th rising edge after the accepting edge; with KEY_LAT=1 this is edge 22.
REQ-026 SHALL emit exactly 1 start_enc pulse and 10 ready_enc pulses per block, never asserting both in the same cycle.
REQ-027 SHALL drive in_ready=0 outside IDLE, ignoring in_valid and data_in there; there is no block overlap.
REQ-028 SHALL support back-to-back blocks: in_ready=1 in the cycle after the DONE handshake.
REQ-029 SHALL register all outputs: in_ready, out_valid, start_enc, ready_enc and data_out.

Reset
REQ-030 SHALL, while rst=1 at a rising edge, force state IDLE, rnd=0, out_valid=0, start_enc=0, ready_enc=0, data_out=0 and the internal state register=0, with in_ready=1 from the first cycle after rst deasserts.
REQ-031 SHALL, on reset mid-operation (REQ, WAIT or DONE), abandon the block, emit no further key pulses and never present its output.
REQ-032 SHALL, while rst=1, ignore in_valid.

Verification
REQ-033 SHALL cover: FIPS-197 C.1, key 000102030405060708090a0b0c0d0e0f loaded into key_expansion, plaintext 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid on edge 22 after accept.
REQ-034 SHALL cover: FIPS-197 App.B, key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32, with exactly 1 start_enc and 10 ready_enc pulses counted and never overlapping.
REQ-035 SHALL cover: out_ready held low 5 cycles after out_valid -> data_out and out_valid stable, in_ready=0 throughout, and in_ready=1 on the cycle after the handshake.
REQ-036 SHALL cover: rst pulsed during round 4 -> out_valid stays 0, no key pulses follow, and the next block (C.1 vector) encrypts correctly.
REQ-037 SHALL cover: two back-to-back C.1 blocks with out_ready=1 and KEY_LAT=3 -> both outputs equal 69c4e0d86a7b0430d8cdb78070b4c55a, each with out_valid on edge 44 after its accept.
